// File: rtl/spi_flash_arbiter_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM state encodings, owner codes
// and the two-port arbitration rule used from both IDLE and the end of GAP.
package spi_flash_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  // On contention the port that did not own the bus last time wins.
  function automatic arb_state_t arbitrate(input logic elig0, input logic elig1,
                                           input logic last_owner);
    if (elig0 && elig1) return last_owner ? ST_GRANT0 : ST_GRANT1;
    else if (elig0)     return ST_GRANT0;
    else if (elig1)     return ST_GRANT1;
    else                return ST_IDLE;
  endfunction

endpackage

// File: rtl/spi_flash_arbiter.sv
// Two-port SPI flash pin arbiter with alternation, a forced chip-select-high gap
// between owners and a watchdog that revokes grants held too long.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int unsigned CS_GAP_CYCLES  = 5,
  parameter int unsigned TIMEOUT_W      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       req0,
  input  logic       csel0,
  input  logic       sclk0,
  input  logic       mosi0,
  output logic       grant0,
  output logic       miso0,
  input  logic       req1,
  input  logic       csel1,
  input  logic       sclk1,
  input  logic       mosi1,
  output logic       grant1,
  output logic       miso1,
  output logic       spi_csel,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [1:0] owner,
  output logic       timeout_err
);

  localparam int unsigned GAP_W = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(CS_GAP_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state;
  arb_state_t           arb_pick;
  logic                 last_owner;
  logic                 revoked0;
  logic                 revoked1;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  always_comb arb_pick = arbitrate(req0 & ~revoked0, req1 & ~revoked1, last_owner);

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_owner  <= 1'b1;
      revoked0    <= 1'b0;
      revoked1    <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      timeout_err <= 1'b0;
      // A revoked port becomes eligible again only after it lets go of req.
      if (!req0) revoked0 <= 1'b0;
      if (!req1) revoked1 <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          state  <= arb_pick;
          wd_cnt <= '0;
          if (arb_pick == ST_GRANT0) last_owner <= 1'b0;
          if (arb_pick == ST_GRANT1) last_owner <= 1'b1;
        end

        ST_GRANT0: begin
          if (!req0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (wd_cnt == WD_LAST) begin
            state       <= ST_GAP;
            gap_cnt     <= GAP_LOAD;
            revoked0    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end

        ST_GRANT1: begin
          if (!req1) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (wd_cnt == WD_LAST) begin
            state       <= ST_GAP;
            gap_cnt     <= GAP_LOAD;
            revoked1    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) begin
            state  <= arb_pick;
            wd_cnt <= '0;
            if (arb_pick == ST_GRANT0) last_owner <= 1'b0;
            if (arb_pick == ST_GRANT1) last_owner <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign grant0 = (state == ST_GRANT0);
  assign grant1 = (state == ST_GRANT1);
  assign owner  = grant0 ? OWNER_P0 : (grant1 ? OWNER_P1 : OWNER_NONE);

  // Pins park with chip select high whenever nobody owns the bus.
  always_comb begin
    spi_csel = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    miso0    = 1'b0;
    miso1    = 1'b0;
    unique case (state)
      ST_GRANT0: begin
        spi_csel = csel0;
        spi_clk  = sclk0;
        spi_mosi = mosi0;
        miso0    = spi_miso;
      end
      ST_GRANT1: begin
        spi_csel = csel1;
        spi_clk  = sclk1;
        spi_mosi = mosi1;
        miso1    = spi_miso;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: a vector table for basic muxing and
// arbitration, then hand-written gap, alternation, reset and watchdog sequences.
module tb_spi_flash_arbiter;
  import spi_flash_arbiter_pkg::*;

  logic clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  logic reset, req0, csel0, sclk0, mosi0, req1, csel1, sclk1, mosi1, spi_miso;
  logic grant0, grant1, miso0, miso1, spi_csel, spi_clk, spi_mosi, timeout_err;
  logic [1:0] owner;

  spi_flash_arbiter #(
    .CS_GAP_CYCLES (5),
    .TIMEOUT_W     (20),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .req0       (req0),
    .csel0      (csel0),
    .sclk0      (sclk0),
    .mosi0      (mosi0),
    .grant0     (grant0),
    .miso0      (miso0),
    .req1       (req1),
    .csel1      (csel1),
    .sclk1      (sclk1),
    .mosi1      (mosi1),
    .grant1     (grant1),
    .miso1      (miso1),
    .spi_csel   (spi_csel),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  // {grant0, grant1, owner, spi_csel, spi_clk, spi_mosi, miso0, miso1, timeout_err}
  logic [9:0] obs;
  assign obs = {grant0, grant1, owner, spi_csel, spi_clk, spi_mosi, miso0, miso1, timeout_err};

  // stim = {reset, req0, csel0, sclk0, mosi0, req1, csel1, sclk1, mosi1, spi_miso}
  typedef struct {
    logic [9:0] stim;
    logic [9:0] expd;
  } vec_t;

  vec_t vecs [11];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic apply(input logic [9:0] v);
    {reset, req0, csel0, sclk0, mosi0, req1, csel1, sclk1, mosi1, spi_miso} = v;
  endtask

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  // First tick is the release edge; expects five cycles parked, then exp_owner.
  task automatic gap_seq(input string nm, input logic [1:0] exp_owner,
                         input logic raise0, input logic raise1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        if (raise0) req0 = 1'b1;
        if (raise1) req1 = 1'b1;
      end
      check($sformatf("%s_gap%0d", nm, i), {owner, spi_csel, spi_clk}, {OWNER_NONE, 2'b10});
    end
    tick();
    check($sformatf("%s_owner", nm), owner, exp_owner);
  endtask

  initial begin
    vecs[0]  = '{10'b1_0_1_0_0_0_1_0_0_1, 10'b0_0_00_1_0_0_0_0_0};
    vecs[1]  = '{10'b0_1_0_1_1_0_1_0_0_1, 10'b1_0_01_0_1_1_1_0_0};
    vecs[2]  = '{10'b0_1_0_0_0_1_0_1_1_0, 10'b1_0_01_0_0_0_0_0_0};
    vecs[3]  = '{10'b0_1_1_1_1_1_0_1_1_1, 10'b1_0_01_1_1_1_1_0_0};
    for (int i = 4; i <= 8; i++)
      vecs[i] = '{10'b0_0_1_0_0_1_0_1_1_1, 10'b0_0_00_1_0_0_0_0_0};
    vecs[9]  = '{10'b0_0_1_0_0_1_0_1_1_1, 10'b0_1_10_0_1_1_0_1_0};
    vecs[10] = '{10'b0_1_1_0_0_1_1_0_0_0, 10'b0_1_10_1_0_0_0_0_0};

    apply(vecs[0].stim);
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].stim);
      tick();
      check($sformatf("vec%0d", i), obs, vecs[i].expd);
    end

    // Port 1 releases while still driving csel low; port 0 is waiting.
    req1 = 1'b0; csel1 = 1'b0; sclk1 = 1'b1; csel0 = 1'b0; spi_miso = 1'b1;
    gap_seq("rel_csel_low", OWNER_P0, 1'b0, 1'b0);
    check("grant0_csel", spi_csel, csel0);

    // Port 0 releases briefly; both requesting at gap end -> port 1.
    req0 = 1'b0;
    gap_seq("alt_to_p1", OWNER_P1, 1'b1, 1'b1);
    // Port 1 releases briefly; both requesting at gap end -> port 0.
    req1 = 1'b0;
    gap_seq("alt_to_p0", OWNER_P0, 1'b0, 1'b1);
    req0 = 1'b0;
    gap_seq("alt_to_p1b", OWNER_P1, 1'b1, 1'b0);

    // Reset in the middle of a port-1 grant.
    csel1 = 1'b0; sclk1 = 1'b1; mosi1 = 1'b1; reset = 1'b1;
    tick();
    check("rst_mid_grant", {grant1, owner, spi_csel, spi_clk}, {1'b0, OWNER_NONE, 2'b10});
    check("rst_terr", timeout_err, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_contention", owner, OWNER_P0);
    req1 = 1'b0;

    // Watchdog: port 0 holds for the full 16-cycle limit.
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("wd_hold%0d", i), {grant0, timeout_err}, 2'b10);
    end
    tick();
    check("wd_revoke", {grant0, owner, spi_csel, timeout_err}, {1'b0, OWNER_NONE, 2'b11});
    tick();
    check("wd_pulse_end", timeout_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("wd_no_regrant%0d", i), owner, OWNER_NONE);
    end
    req0 = 1'b0;
    tick();
    check("wd_drop", owner, OWNER_NONE);
    req0 = 1'b1;
    tick();
    check("wd_regrant", owner, OWNER_P0);

    // Release lands on the same edge that would have timed out.
    for (int i = 1; i < 16; i++) tick();
    check("same_edge_pre", grant0, 1'b1);
    req0 = 1'b0;
    tick();
    check("same_edge_rel", {owner, timeout_err}, {OWNER_NONE, 1'b0});
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("same_edge_gap%0d", i), {owner, timeout_err}, {OWNER_NONE, 1'b0});
    end
    tick();
    check("same_edge_regrant", owner, OWNER_P0);

    req0 = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
Shares the single SPI flash pin set (spi_csel/spi_clk/spi_mosi/spi_miso) between two requesters: port 0 (DFU programming engine in usb_dfu_core) and port 1 (boot-config/image reader).
- Grants exclusive ownership per request.
- Enforces a minimum chip-select-high gap between owners.
- Alternates owners on contention.
- Revokes ownership held longer than a watchdog limit.
- Sits between the DFU core's SPI outputs and the top-level flash pins.

Parameters:
CS_GAP_CYCLES, 5, cycles spi_csel is forced high after every release/revoke (≥1; 5 cycles ≈ 104 ns at 48 MHz).
TIMEOUT_W, 20, watchdog counter width.
TIMEOUT_CYCLES, 20'hFFFFF, maximum cycles a grant may be held before revoke (≥1, < 2^TIMEOUT_W).

Ports:
clk_48mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
req0  in  1  port-0 bus request (level, held for whole transaction)
csel0  in  1  port-0 chip select (active low)
sclk0  in  1  port-0 SPI clock
mosi0  in  1  port-0 data out
grant0  out  1  port-0 owns bus
miso0  out  1  flash data to port 0
req1, csel1, sclk1, mosi1  in  1 each  port-1 equivalents
grant1  out  1  port-1 owns bus
miso1  out  1  flash data to port 1
spi_csel  out  1  flash chip select
spi_clk  out  1  flash clock
spi_mosi  out  1  flash data in
spi_miso  in  1  flash data out
owner  out  2  2'b00 none, 2'b01 port 0, 2'b10 port 1
timeout_err  out  1  one-cycle pulse on watchdog revoke

Behaviour:
- Clock is clk_48mhz. Reset is synchronous and active-high on port reset. All state updates on the rising edge.
- States: IDLE, GRANT0, GRANT1, GAP.
- Reset values:
  - state=IDLE, grant0=grant1=0, owner=2'b00, timeout_err=0.
  - spi_csel=1, spi_clk=0, spi_mosi=0, miso0=miso1=0.
  - last_owner=1, so port 0 wins the first contention.
  - revoked0=revoked1=0.
- Pin mux (combinational from state):
  - GRANTn: spi_csel/spi_clk/spi_mosi = cseln/sclkn/moson. misoN = spi_miso; the other port's miso = 0.
  - IDLE/GAP: spi_csel=1, spi_clk=0, spi_mosi=0, both miso = 0.
- grantn and owner decode registered state only.
- Eligibility: elign = reqn & ~revokedn.
- IDLE:
  - Only one port eligible: go to GRANTn.
  - Both eligible: grant the port ≠ last_owner.
  - Latency: req sampled high at edge N → grant high after edge N.
- Entering GRANTn: last_owner←n; watchdog counter←0.
- GRANTn:
  - Counter increments each cycle.
  - reqn sampled low → GAP.
  - Counter reaches TIMEOUT_CYCLES-1 with reqn still high → GAP, revokedn←1, timeout_err=1 for exactly that transition cycle.
  - Release takes priority over timeout when both occur on the same edge; no error in that case.
- GAP:
  - Gap counter loaded with CS_GAP_CYCLES-1 on entry. The state occupies exactly CS_GAP_CYCLES cycles with spi_csel=1.
  - At counter==0, arbitrate as IDLE directly (GRANT0, GRANT1 or IDLE).
  - Earliest regrant is CS_GAP_CYCLES+1 cycles after the release edge.
- Revoke clearing: revokedn clears when reqn is sampled low. A revoked port must drop req for ≥1 cycle before it is eligible again.
- Requester deasserting req while its csel is low: pins go csel-high on the next cycle (GAP). The arbiter does not wait for the requester's csel.
- A request arriving during GAP is queued implicitly. It is served at gap end by the alternation rule.
- Reset mid-grant: IDLE on the next edge, csel high immediately, no gap enforced, revoke flags cleared.

Decomposition:
- Shared header spi_arb_defs.vh holds:
  - state encodings (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, GAP=2'd3)
  - owner codes
- No sub-module. Gap and watchdog counters are inline; total RTL about 150–200 lines.

Test Plan:
- Reset, then req0=1 at cycle 10 → grant0=1 and owner=01 at cycle 11. spi_csel follows csel0; miso0 mirrors spi_miso; miso1=0.
- req0 and req1 both high from IDLE after reset → port 0 granted. Drop req0 → GAP of exactly 5 cycles with spi_csel=1, then grant1. Reissue both → port 0 next (alternation).
- Port 1 owns bus. req1 drops while csel1=0 → spi_csel=1 on the next cycle. req0 pending → grant0 asserts 6 cycles after the release edge.
- TIMEOUT_CYCLES=16, req0 held:
  - grant drops after 16 cycles and timeout_err pulses 1 cycle.
  - req0 kept high → no regrant.
  - req0 low 1 cycle then high → granted after the gap.
- Release and timeout on the same edge (TIMEOUT_CYCLES=16, req0 drops in cycle 16) → GAP entered, timeout_err stays 0, revoked0 stays 0.
- reset asserted during GRANT1 → next cycle: grant1=0, owner=00, spi_csel=1, spi_clk=0. After reset, simultaneous requests → port 0 wins.
